max7219_driver: RTL and testbench

Serial display back-end for the clock. Takes eight packed BCD digits from the cascaded `counter`-style digit stages and drives a MAX7219 8-digit 7-segment controller over a write-only 3-wire SPI link. After reset it sends the controller's configuration sequence once. Each `ena` tick then triggers a refresh of all eight digit registers.

---
 rtl/max7219_driver.sv | 152 +++++++++++++++
 tb/tb_max7219_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_driver.sv
// MAX7219 serial back-end: sends the configuration frames once after reset, then
// refreshes all eight BCD digit registers on every ena request.
module max7219_driver #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ena,
    input  logic [31:0] digits,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi
);

    typedef enum logic [1:0] {INIT, IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic        pending, pending_n;
    logic        init_seq, init_seq_n;
    logic [31:0] shadow, shadow_n;
    logic [15:0] sreg, sreg_n;
    logic [7:0]  div, div_n;
    logic [5:0]  half, half_n;
    logic [2:0]  fidx, fidx_n;
    logic        div_end, last_frame;

    function automatic logic [15:0] frame(input logic is_init, input logic [2:0] idx,
                                          input logic [31:0] sh);
        logic [15:0] f;
        if (is_init) begin
            case (idx)
                3'd0:    f = 16'h0C01;
                3'd1:    f = 16'h0F00;
                3'd2:    f = 16'h09FF;
                3'd3:    f = {12'h0A0, INTENSITY};
                default: f = 16'h0B07;
            endcase
        end else begin
            f = {4'h0, {1'b0, idx} + 4'd1, 4'h0, sh[{idx, 2'b00} +: 4]};
        end
        return f;
    endfunction

    assign div_end    = (div == DIV_LAST);
    assign last_frame = init_seq ? (fidx == 3'd4) : (fidx == 3'd7);

    always_comb begin
        state_n    = state;
        pending_n  = pending;
        init_seq_n = init_seq;
        shadow_n   = shadow;
        sreg_n     = sreg;
        div_n      = div;
        half_n     = half;
        fidx_n     = fidx;
        case (state)
            INIT: begin
                if (ena) pending_n = 1'b1;
                init_seq_n = 1'b1;
                fidx_n     = '0;
                sreg_n     = frame(1'b1, 3'd0, shadow);
                div_n      = '0;
                half_n     = '0;
                state_n    = SHIFT;
            end
            IDLE: begin
                if (ena || pending) begin
                    shadow_n   = digits;
                    pending_n  = 1'b0;
                    init_seq_n = 1'b0;
                    fidx_n     = '0;
                    sreg_n     = frame(1'b0, 3'd0, digits);
                    div_n      = '0;
                    half_n     = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (ena) pending_n = 1'b1;
                // Half-period 32 is the single extra cycle that holds cs low after the last fall.
                if (half == 6'd32) begin
                    div_n   = '0;
                    half_n  = '0;
                    state_n = GAP;
                end else if (div_end) begin
                    div_n  = '0;
                    half_n = half + 6'd1;
                    if (half[0]) sreg_n = {sreg[14:0], 1'b0};
                end else begin
                    div_n = div + 8'd1;
                end
            end
            GAP: begin
                if (ena) pending_n = 1'b1;
                if (div_end) begin
                    div_n = '0;
                    if (half[0]) begin
                        half_n = '0;
                        if (last_frame) begin
                            state_n = IDLE;
                        end else begin
                            fidx_n  = fidx + 3'd1;
                            sreg_n  = frame(init_seq, fidx + 3'd1, shadow);
                            state_n = SHIFT;
                        end
                    end else begin
                        half_n = half + 6'd1;
                    end
                end else begin
                    div_n = div + 8'd1;
                end
            end
            default: state_n = INIT;
        endcase
    end

    // Outputs are registered from next-state values so the pins never glitch.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= INIT;
            pending  <= 1'b0;
            init_seq <= 1'b0;
            shadow   <= '0;
            sreg     <= '0;
            div      <= '0;
            half     <= '0;
            fidx     <= '0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            init_seq <= init_seq_n;
            shadow   <= shadow_n;
            sreg     <= sreg_n;
            div      <= div_n;
            half     <= half_n;
            fidx     <= fidx_n;
            spi_cs   <= (state_n != SHIFT);
            spi_clk  <= (state_n == SHIFT) && half_n[0];
            spi_mosi <= (state_n == SHIFT) && sreg_n[15];
            busy     <= (state_n != IDLE) || pending_n;
        end
    end

endmodule

// File: tb/tb_max7219_driver.sv
// Bench for max7219_driver: two configurations side by side, each checked every cycle
// against a frame-timing model, with the serial frames decoded off the wire.
module tb_max7219_driver;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        ena = 1'b0;
    logic [31:0] digits = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          armed = 1'b0;

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int         D   = (g == 0) ? 4 : 1;
        localparam logic [3:0] INT = (g == 0) ? 4'h8 : 4'hF;
        localparam int         P   = 34 * D + 1;
        localparam logic [15:0] INT_LIT = (g == 0) ? 16'h0A08 : 16'h0A0F;

        logic busy, spi_cs, spi_clk, spi_mosi;

        max7219_driver #(.CLK_DIV(D), .INTENSITY(INT)) dut (
            .clk(clk), .res(res), .ena(ena), .digits(digits),
            .busy(busy), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi)
        );

        int          ecnt = 0, s_edge = 0, nfr = 0, busy_cyc = 0, since_rst = 0;
        int          k, f, o, bitcnt = 0;
        bit          m_run = 1'b0, m_wait = 1'b1, m_pend = 1'b0;
        logic [15:0] fr [8];
        logic [15:0] exp_q [$];
        logic [15:0] rxq [$];
        logic [15:0] rx = '0;
        logic        e_cs, e_clk, e_mosi, e_busy, cs_prev = 1'b1, clk_prev = 1'b0;
        bit          chk_mosi;

        // Model: a sequence of N frames started at edge s holds cs low for the first
        // 32D+1 cycles of every P-cycle slot; ena outside idle collapses into one request.
        always @(posedge clk) begin
            ecnt++;
            if (!res) begin
                m_wait = 1'b1; m_run = 1'b0; m_pend = 1'b0;
                exp_q.delete();
                busy_cyc = 0;
            end else begin
                if (busy) busy_cyc++;
                if (m_wait) begin
                    fr[0] = 16'h0C01; fr[1] = 16'h0F00; fr[2] = 16'h09FF;
                    fr[3] = {12'h0A0, INT}; fr[4] = 16'h0B07;
                    nfr = 5; s_edge = ecnt; m_run = 1'b1; m_wait = 1'b0; m_pend = ena;
                    for (int i = 0; i < 5; i++) exp_q.push_back(fr[i]);
                end else if (m_run) begin
                    if (ena) m_pend = 1'b1;
                    if (ecnt == s_edge + nfr * P) m_run = 1'b0;
                end else if (ena || m_pend) begin
                    for (int n = 1; n <= 8; n++)
                        fr[n-1] = 16'(n * 256) | 16'((digits >> (4 * (n - 1))) & 32'hF);
                    nfr = 8; s_edge = ecnt; m_run = 1'b1; m_pend = 1'b0;
                    for (int i = 0; i < 8; i++) exp_q.push_back(fr[i]);
                end
            end
            #1;
            if (armed) begin
                chk_mosi = 1'b0; e_mosi = 1'b0;
                if (!res) begin
                    e_cs = 1'b1; e_clk = 1'b0; e_busy = 1'b1; chk_mosi = 1'b1;
                end else begin
                    e_busy = m_run || m_pend;
                    if (m_run) begin
                        k = ecnt - s_edge; f = k / P; o = k % P;
                        e_cs  = !(o < 32 * D + 1);
                        e_clk = (o < 32 * D) ? 1'((o / D) % 2) : 1'b0;
                        if (o < 32 * D) begin
                            chk_mosi = 1'b1;
                            e_mosi = fr[f][15 - o / (2 * D)];
                        end
                    end else begin
                        e_cs = 1'b1; e_clk = 1'b0;
                    end
                end
                check($sformatf("cfg%0d.cs", g), 32'(spi_cs), 32'(e_cs));
                check($sformatf("cfg%0d.sclk", g), 32'(spi_clk), 32'(e_clk));
                check($sformatf("cfg%0d.busy", g), 32'(busy), 32'(e_busy));
                if (chk_mosi) check($sformatf("cfg%0d.mosi", g), 32'(spi_mosi), 32'(e_mosi));
            end
        end

        // Wire-level decoder: sample mosi on sclk rise while cs low, close frame on cs rise.
        always @(spi_clk or spi_cs or res) begin
            if (!res) begin
                bitcnt = 0;
                since_rst = 0;
            end else begin
                if (!spi_cs && cs_prev) bitcnt = 0;
                if (spi_clk && !clk_prev && !spi_cs) begin
                    rx = {rx[14:0], spi_mosi};
                    bitcnt++;
                end
                if (spi_cs && !cs_prev) begin
                    check($sformatf("cfg%0d.bits", g), 32'(bitcnt), 32'd16);
                    rxq.push_back(rx);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL cfg%0d.frame: got %h expected none", g, rx);
                    end else begin
                        check($sformatf("cfg%0d.frame", g), 32'(rx), 32'(exp_q.pop_front()));
                    end
                    if (since_rst < 5) begin
                        case (since_rst)
                            0: check($sformatf("cfg%0d.init0", g), 32'(rx), 32'h0C01);
                            1: check($sformatf("cfg%0d.init1", g), 32'(rx), 32'h0F00);
                            2: check($sformatf("cfg%0d.init2", g), 32'(rx), 32'h09FF);
                            3: check($sformatf("cfg%0d.init3", g), 32'(rx), 32'(INT_LIT));
                            default: check($sformatf("cfg%0d.init4", g), 32'(rx), 32'h0B07);
                        endcase
                    end
                    since_rst++;
                end
            end
            cs_prev  = spi_cs;
            clk_prev = spi_clk;
        end
    end

    function automatic logic [15:0] rx_at(input int g, input int i);
        return (g == 0) ? cfg[0].rxq[i] : cfg[1].rxq[i];
    endfunction

    function automatic int rx_n(input int g);
        return (g == 0) ? cfg[0].rxq.size() : cfg[1].rxq.size();
    endfunction

    task automatic pulse();
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((cfg[0].busy || cfg[1].busy) && c < maxc) begin
            @(posedge clk); #2; c++;
        end
        if (cfg[0].busy || cfg[1].busy) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: busy still high after %0d cycles", maxc);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_pins();
        check("rst0.cs", 32'(cfg[0].spi_cs), 32'd1);
        check("rst0.sclk", 32'(cfg[0].spi_clk), 32'd0);
        check("rst0.mosi", 32'(cfg[0].spi_mosi), 32'd0);
        check("rst0.busy", 32'(cfg[0].busy), 32'd1);
        check("rst1.cs", 32'(cfg[1].spi_cs), 32'd1);
        check("rst1.sclk", 32'(cfg[1].spi_clk), 32'd0);
        check("rst1.mosi", 32'(cfg[1].spi_mosi), 32'd0);
        check("rst1.busy", 32'(cfg[1].busy), 32'd1);
    endtask

    int base[2];
    int c;

    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        check_reset_pins();
        @(negedge clk) res = 1'b1;
        wait_idle(5000);
        check("init_cycles0", 32'(cfg[0].busy_cyc), 32'd686);
        check("init_cycles1", 32'(cfg[1].busy_cyc), 32'd176);

        // Plain refresh
        for (int g = 0; g < 2; g++) base[g] = rx_n(g);
        digits = 32'h8765_4321;
        pulse();
        wait_idle(5000);
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 8; i++)
                check($sformatf("refresh%0d.%0d", g, i), 32'(rx_at(g, base[g] + i)), 32'(16'h0101 * (i + 1)));

        // Digits change mid-refresh; nibbles 10-15 pass through
        digits = 32'hA9F3_0C57;
        pulse();
        repeat (150) @(negedge clk);
        digits = '0;
        wait_idle(5000);
        for (int g = 0; g < 2; g++)
            check($sformatf("midchg%0d", g), 32'(rx_at(g, rx_n(g) - 1)), 32'h080A);

        // Three requests during a refresh collapse into one follow-up refresh
        for (int g = 0; g < 2; g++) base[g] = rx_n(g);
        digits = 32'h1111_1111;
        pulse();
        for (int j = 0; j < 3; j++) begin
            repeat (20) @(negedge clk);
            digits = 32'h3333_3333;
            pulse();
        end
        digits = 32'h2222_2222;
        wait_idle(5000);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("collapse_n%0d", g), 32'(rx_n(g) - base[g]), 32'd16);
            check($sformatf("collapse_last%0d", g), 32'(rx_at(g, rx_n(g) - 1)), 32'h0802);
        end

        // Randomized requests and digit changes
        repeat (40) begin
            repeat ($urandom_range(1, 500)) @(negedge clk);
            digits = $urandom;
            if ($urandom_range(0, 2) != 0) pulse();
        end
        wait_idle(5000);

        // Reset in the middle of bit 7 of the first refresh frame
        pulse();
        c = 0;
        while (cfg[0].spi_cs && c < 50) begin
            @(posedge clk); #1; c++;
        end
        check("cs_fall_wait", 32'(cfg[0].spi_cs), 32'd0);
        repeat (66) @(posedge clk);
        #2 res = 1'b0;
        #1 check_reset_pins();
        repeat (3) @(negedge clk);
        res = 1'b1;
        wait_idle(5000);
        check("reinit_cycles0", 32'(cfg[0].busy_cyc), 32'd686);
        check("reinit_cycles1", 32'(cfg[1].busy_cyc), 32'd176);

        repeat (5) @(negedge clk);
        check("exp_left0", 32'(cfg[0].exp_q.size()), 32'd0);
        check("exp_left1", 32'(cfg[1].exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
